conv_bit_feeder: RTL and testbench
==================================

# conv_bit_feeder

Upstream stage of the bit-serial convolution core. Holds one 25-tap window of 8-bit activations (X) and 8-bit weights (K) loaded over a byte-wide write port. On start, it streams the window as bit-slices, one bit of every tap per slice. Each slice is delivered through the core's valid/ready four-phase-style handshake, followed by zero pad slices that flush the serial multipliers.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per X/K operand
- KERNEL_SIZE, 25, taps per window
- PAD_SLICES, 5, zero slices appended after the data slices; total slices N_SLICES = DATA_WIDTH + PAD_SLICES
- MSB_FIRST, 0, 0 = bit 0 sent first, 1 = bit DATA_WIDTH-1 sent first

Ports:
- i_clk  in  1  clock; single clock domain
- i_arstn  in  1  asynchronous active-low reset
- i_load_valid  in  1  write strobe for the operand store
- i_load_sel  in  1  0 = X store, 1 = K store
- i_load_idx  in  5  tap index
- i_load_data  in  DATA_WIDTH  operand byte
- o_load_ready  out  1  store writable (high only in IDLE)
- i_start  in  1  begin streaming the stored window
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse after the last slice is accepted
- o_valid  out  1  slice valid, to the core's i_valid
- o_bit_X  out  KERNEL_SIZE  X bit-slice, to the core's i_bit_X
- o_bit_K  out  KERNEL_SIZE  K bit-slice, to the core's i_bit_K
- i_ready  in  1  core ready, from the core's o_ready

## Operation
- Store: two arrays of KERNEL_SIZE × DATA_WIDTH flops.
  - A write occurs when i_load_valid & o_load_ready & (i_load_idx < KERNEL_SIZE).
  - Out-of-range indices are silently dropped.
  - Contents persist across windows, so only changed taps need reloading.
- Slice j (j = 0 … N_SLICES-1):
  - For j < DATA_WIDTH: o_bit_X[t] = X[t][b] and o_bit_K[t] = K[t][b], where b = j if MSB_FIRST = 0, else DATA_WIDTH-1-j.
  - For j ≥ DATA_WIDTH: both slices are all zeros.
- FSM states: IDLE, ARM, PRESENT, DONE.
  - IDLE: o_load_ready = 1. i_start → ARM, slice counter cleared to 0.
  - ARM: o_valid = 0. When i_ready is sampled high → PRESENT; slice j is registered onto o_bit_X/o_bit_K on the same edge.
  - PRESENT: o_valid = 1, data held stable. When i_ready is sampled low, the core has captured the slice:
    - If j = N_SLICES-1 → DONE.
    - Otherwise j increments → ARM.
  - DONE: o_done = 1 for one cycle → IDLE.
- Passing through ARM guarantees at least one cycle of o_valid low between slices. This releases the core's read-done wait and prevents a double capture when the core returns to IDLE after a result write.
- i_start outside IDLE is ignored.
- i_load_valid outside IDLE is ignored; o_load_ready is 0 there.
- i_start and a load write in the same IDLE cycle: the write lands first and is included in the window.

## Timing
- Reset values: state IDLE; o_valid 0, o_busy 0, o_done 0, o_load_ready 1; o_bit_X and o_bit_K all 0; slice counter 0; store all 0.
- All outputs are registered or decoded from the state register; there is no combinational path from any input to any output.
- i_start at edge n → ARM in cycle n+1 → earliest o_valid in cycle n+2.
- The core captures the slice on the edge that ends its READ cycle. The feeder changes data only on the edge after it observes i_ready low, so the captured data is always stable.
- Against the core with no result write: 5 cycles per slice (PRESENT, core READ, ARM, ARM, PRESENT). A result write adds cycles until the downstream consumer toggles ready.
- A window takes N_SLICES handshakes. o_done is asserted one cycle after the final PRESENT exit.
- Reset asserted mid-window: everything returns to reset values immediately (asynchronous). The store is cleared and the window is lost.
- i_ready held low forever in ARM: the feeder waits indefinitely with o_valid 0. There is no timeout.

## Structure
- Shared package conv_pkg holds:
  - feeder_state_t, 2-bit enum: IDLE = 0, ARM = 1, PRESENT = 2, DONE = 3.
  - load_sel_t, 1-bit enum: SEL_X, SEL_K.
  - Default localparams DATA_WIDTH = 8, KERNEL_SIZE = 25.
- One sub-module, conv_slice_mux: purely combinational. Takes a store array and bit index b, produces the KERNEL_SIZE-wide slice. Instantiated twice, once for X and once for K.

## Test plan
- Reset: hold i_arstn low, then release → o_valid 0, o_load_ready 1, o_bit_X = 0, o_busy 0.
- Load X[t] = t+1 and K[t] = 8'hFF for all t, start with a behavioural core model (ready drops 1 cycle after valid, rises 3 cycles later):
  - 13 slices are delivered.
  - Slice 0: o_bit_X = bit 0 of each (t+1), o_bit_K = all ones.
  - Slices 8–12 are all zeros.
  - o_done pulses once.
- MSB_FIRST = 1 with X[0] = 8'h80, all other taps 0 → o_bit_X[0] = 1 in slice 0 only.
- Core holds ready low for 10 cycles after a slice (write phase) → o_valid stays 0 throughout ARM; no slice is duplicated or skipped (count = 13).
- Load write with idx 25, plus i_start and a load write during PRESENT → store unchanged, FSM unaffected.
- Assert i_arstn low in PRESENT at slice 4 → o_valid is 0 immediately; a fresh load and start then produces a full 13-slice window.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and defaults for the bit-serial convolution front end.
// Used by the operand feeder and its slice multiplexers.
package conv_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int KERNEL_SIZE = 25;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } feeder_state_t;

    typedef enum logic {
        SEL_X = 1'b0,
        SEL_K = 1'b1
    } load_sel_t;

endpackage

// File: rtl/conv_bit_feeder_if.sv
// Bundle of the feeder's load port and slice handshake.
// master = feeder side, slave = loader/core side.
interface conv_bit_feeder_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 25
);

    logic                   load_valid;
    logic                   load_sel;
    logic [4:0]             load_idx;
    logic [DATA_WIDTH-1:0]  load_data;
    logic                   load_ready;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   valid;
    logic [KERNEL_SIZE-1:0] bit_x;
    logic [KERNEL_SIZE-1:0] bit_k;
    logic                   ready;

    modport master (
        input  load_valid, load_sel, load_idx, load_data,
        input  start, ready,
        output load_ready, busy, done, valid, bit_x, bit_k
    );

    modport slave (
        output load_valid, load_sel, load_idx, load_data,
        output start, ready,
        input  load_ready, busy, done, valid, bit_x, bit_k
    );

endinterface

// File: rtl/conv_slice_mux.sv
// Picks one bit position out of every tap of an operand store.
// Purely combinational; one instance per operand array.
module conv_slice_mux #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 25,
    parameter int BW          = 3
) (
    input  logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] i_store,
    input  logic [BW-1:0]                          i_bit,
    output logic [KERNEL_SIZE-1:0]                 o_slice
);

    always_comb begin
        o_slice = '0;
        for (int t = 0; t < KERNEL_SIZE; t++) begin
            o_slice[t] = i_store[t][i_bit];
        end
    end

endmodule

// File: rtl/conv_bit_feeder.sv
// Holds one X/K window and streams it as bit-slices over a
// valid/ready handshake, followed by zero pad slices.
module conv_bit_feeder #(
    parameter int DATA_WIDTH  = conv_pkg::DATA_WIDTH,
    parameter int KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
    parameter int PAD_SLICES  = 5,
    parameter int MSB_FIRST   = 0
) (
    input  logic                   i_clk,
    input  logic                   i_arstn,
    input  logic                   i_load_valid,
    input  logic                   i_load_sel,
    input  logic [4:0]             i_load_idx,
    input  logic [DATA_WIDTH-1:0]  i_load_data,
    output logic                   o_load_ready,
    input  logic                   i_start,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_valid,
    output logic [KERNEL_SIZE-1:0] o_bit_X,
    output logic [KERNEL_SIZE-1:0] o_bit_K,
    input  logic                   i_ready
);

    import conv_pkg::*;

    localparam int N_SLICES = DATA_WIDTH + PAD_SLICES;
    localparam int SW = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] store_t;

    feeder_state_t          state_q, state_d;
    logic [SW-1:0]          slice_q, slice_d;
    store_t                 x_q, x_d;
    store_t                 k_q, k_d;
    logic [KERNEL_SIZE-1:0] bit_x_q, bit_x_d;
    logic [KERNEL_SIZE-1:0] bit_k_q, bit_k_d;

    logic [BW-1:0]          bit_idx;
    logic                   in_data;
    logic                   wr_en;
    logic [KERNEL_SIZE-1:0] mux_x;
    logic [KERNEL_SIZE-1:0] mux_k;

    conv_slice_mux #(
        .DATA_WIDTH  (DATA_WIDTH),
        .KERNEL_SIZE (KERNEL_SIZE),
        .BW          (BW)
    ) u_mux_x (
        .i_store (x_q),
        .i_bit   (bit_idx),
        .o_slice (mux_x)
    );

    conv_slice_mux #(
        .DATA_WIDTH  (DATA_WIDTH),
        .KERNEL_SIZE (KERNEL_SIZE),
        .BW          (BW)
    ) u_mux_k (
        .i_store (k_q),
        .i_bit   (bit_idx),
        .o_slice (mux_k)
    );

    // Slices past the data bits are pad; the index may wrap there.
    always_comb begin
        in_data = int'(slice_q) < DATA_WIDTH;
        if (MSB_FIRST != 0) begin
            bit_idx = BW'(DATA_WIDTH - 1 - int'(slice_q));
        end else begin
            bit_idx = BW'(slice_q);
        end
    end

    assign wr_en = i_load_valid && (state_q == IDLE) &&
                   (int'(i_load_idx) < KERNEL_SIZE);

    always_comb begin
        x_d = x_q;
        k_d = k_q;
        for (int t = 0; t < KERNEL_SIZE; t++) begin
            if (wr_en && (i_load_idx == 5'(t))) begin
                if (load_sel_t'(i_load_sel) == SEL_K) begin
                    k_d[t] = i_load_data;
                end else begin
                    x_d[t] = i_load_data;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        slice_d = slice_q;
        bit_x_d = bit_x_q;
        bit_k_d = bit_k_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = ARM;
                    slice_d = '0;
                end
            end
            ARM: begin
                if (i_ready) begin
                    state_d = PRESENT;
                    bit_x_d = in_data ? mux_x : '0;
                    bit_k_d = in_data ? mux_k : '0;
                end
            end
            PRESENT: begin
                // Ready falling means the core has taken this slice.
                if (!i_ready) begin
                    if (slice_q == SW'(N_SLICES - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ARM;
                        slice_d = slice_q + SW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q <= IDLE;
            slice_q <= '0;
            x_q     <= '0;
            k_q     <= '0;
            bit_x_q <= '0;
            bit_k_q <= '0;
        end else begin
            state_q <= state_d;
            slice_q <= slice_d;
            x_q     <= x_d;
            k_q     <= k_d;
            bit_x_q <= bit_x_d;
            bit_k_q <= bit_k_d;
        end
    end

    assign o_load_ready = (state_q == IDLE);
    assign o_busy       = (state_q != IDLE);
    assign o_done       = (state_q == DONE);
    assign o_valid      = (state_q == PRESENT);
    assign o_bit_X      = bit_x_q;
    assign o_bit_K      = bit_k_q;

endmodule

// File: tb/tb_conv_bit_feeder.sv
// Directed bench for conv_bit_feeder: LSB-first and MSB-first
// instances share stimulus and are checked against a window model.
module tb_conv_bit_feeder;

    localparam int DW = 8;
    localparam int KS = 25;
    localparam int NS = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_bit_feeder_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS)) bus ();

    logic          m_load_ready, m_busy, m_done, m_valid;
    logic [KS-1:0] m_bit_x, m_bit_k;

    conv_bit_feeder #(.MSB_FIRST(0)) dut (
        .i_clk        (clk),
        .i_arstn      (rst_n),
        .i_load_valid (bus.load_valid),
        .i_load_sel   (bus.load_sel),
        .i_load_idx   (bus.load_idx),
        .i_load_data  (bus.load_data),
        .o_load_ready (bus.load_ready),
        .i_start      (bus.start),
        .o_busy       (bus.busy),
        .o_done       (bus.done),
        .o_valid      (bus.valid),
        .o_bit_X      (bus.bit_x),
        .o_bit_K      (bus.bit_k),
        .i_ready      (bus.ready)
    );

    conv_bit_feeder #(.MSB_FIRST(1)) dut_m (
        .i_clk        (clk),
        .i_arstn      (rst_n),
        .i_load_valid (bus.load_valid),
        .i_load_sel   (bus.load_sel),
        .i_load_idx   (bus.load_idx),
        .i_load_data  (bus.load_data),
        .o_load_ready (m_load_ready),
        .i_start      (bus.start),
        .o_busy       (m_busy),
        .o_done       (m_done),
        .o_valid      (m_valid),
        .o_bit_X      (m_bit_x),
        .o_bit_K      (m_bit_k),
        .i_ready      (bus.ready)
    );

    logic [7:0]    mx [KS];
    logic [7:0]    mk [KS];
    logic [KS-1:0] cap_x [NS];
    logic [KS-1:0] cap_k [NS];
    logic [KS-1:0] cap_mx [NS];
    logic [KS-1:0] cap_mk [NS];

    int n_chk = 0;
    int n_pass = 0;
    int cap_cnt = 0;
    int done_cnt = 0;
    int extra_hold = 0;
    int hold = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [KS-1:0] exp_slice(input bit is_k,
                                                input int j,
                                                input bit msb);
        logic [KS-1:0] r;
        int b;
        r = '0;
        if (j < DW) begin
            b = msb ? DW - 1 - j : j;
            for (int t = 0; t < KS; t++)
                r[t] = is_k ? mk[t][b] : mx[t][b];
        end
        return r;
    endfunction

    // Core model and compare process.
    initial begin
        bus.ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.ready = 1'b1;
                hold = 0;
            end else begin
                if (bus.done) done_cnt++;
                if (bus.ready) begin
                    if (bus.valid) begin
                        if (cap_cnt >= NS) begin
                            chk("extra_slice", cap_cnt, NS - 1);
                        end else begin
                            cap_x[cap_cnt]  = bus.bit_x;
                            cap_k[cap_cnt]  = bus.bit_k;
                            cap_mx[cap_cnt] = m_bit_x;
                            cap_mk[cap_cnt] = m_bit_k;
                            chk("slice_x", bus.bit_x, exp_slice(0, cap_cnt, 0));
                            chk("slice_k", bus.bit_k, exp_slice(1, cap_cnt, 0));
                            chk("msb_slice_x", m_bit_x, exp_slice(0, cap_cnt, 1));
                            chk("msb_slice_k", m_bit_k, exp_slice(1, cap_cnt, 1));
                            chk("msb_valid", m_valid, 1);
                        end
                        cap_cnt++;
                        bus.ready = 1'b0;
                        hold = 3 + extra_hold;
                    end
                end else begin
                    chk("arm_valid_low", bus.valid, 0);
                    hold--;
                    if (hold <= 0) bus.ready = 1'b1;
                end
            end
        end
    end

    task automatic load(input bit sel, input int idx, input logic [7:0] d,
                        input bit upd);
        @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_sel   = sel;
        bus.load_idx   = 5'(idx);
        bus.load_data  = d;
        if (upd && idx < KS) begin
            if (sel) mk[idx] = d;
            else mx[idx] = d;
        end
        @(negedge clk);
        bus.load_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int c = 0; c < 3000 && done_cnt == 0; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("slice_count", cap_cnt, NS);
        chk("done_pulses", done_cnt, 1);
        chk("idle_busy", bus.busy, 0);
        chk("idle_load_ready", bus.load_ready, 1);
    endtask

    task automatic run_window(input int xh, input bit with_load,
                              input int li, input logic [7:0] ld);
        extra_hold = xh;
        cap_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        if (with_load) begin
            bus.load_valid = 1'b1;
            bus.load_sel   = 1'b0;
            bus.load_idx   = 5'(li);
            bus.load_data  = ld;
            mx[li] = ld;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.load_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.load_sel   = 1'b0;
        bus.load_idx   = '0;
        bus.load_data  = '0;
        bus.start      = 1'b0;
        for (int t = 0; t < KS; t++) begin
            mx[t] = '0;
            mk[t] = '0;
        end

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", bus.valid, 0);
        chk("rst_load_ready", bus.load_ready, 1);
        chk("rst_bit_x", bus.bit_x, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);

        // Ramp window, all-ones weights.
        for (int t = 0; t < KS; t++) begin
            load(0, t, 8'(t + 1), 1);
            load(1, t, 8'hFF, 1);
        end
        run_window(0, 0, 0, 8'h00);
        chk("lit_slice0_x", cap_x[0], 32'h1555555);
        chk("lit_slice0_k", cap_k[0], 32'h1FFFFFF);
        chk("lit_slice8_x", cap_x[8], 0);
        chk("lit_slice12_k", cap_k[12], 0);
        chk("lit_msb0_x", cap_mx[0], 0);

        // Long write phase between slices.
        run_window(10, 0, 0, 8'h00);

        // Single MSB tap; X[0] written in the start cycle.
        for (int t = 1; t < KS; t++) load(0, t, 8'h00, 1);
        run_window(0, 1, 0, 8'h80);
        chk("lit_msb_first_s0", cap_mx[0], 32'h1);
        chk("lit_msb_first_s1", cap_mx[1], 0);
        chk("lit_lsb_first_s7", cap_x[7], 32'h1);
        chk("lit_lsb_first_s0", cap_x[0], 0);

        // Out-of-range write, then start/load while presenting.
        load(0, 25, 8'hAA, 0);
        load(0, 31, 8'h55, 0);
        extra_hold = 0;
        cap_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 200 && !bus.valid; c++) @(negedge clk);
        chk("present_load_ready", bus.load_ready, 0);
        bus.start      = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_sel   = 1'b0;
        bus.load_idx   = 5'd3;
        bus.load_data  = 8'h77;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.load_valid = 1'b0;
        wait_done();

        // Reset while slice 4 is presented.
        extra_hold = 0;
        cap_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 500 && cap_cnt < 4; c++) @(negedge clk);
        for (int c = 0; c < 50 && !bus.valid; c++) begin
            @(posedge clk);
            #1;
        end
        chk("pre_reset_valid", bus.valid, 1);
        rst_n = 1'b0;
        #1;
        chk("areset_valid", bus.valid, 0);
        chk("areset_busy", bus.busy, 0);
        chk("areset_load_ready", bus.load_ready, 1);
        chk("areset_bit_x", bus.bit_x, 0);
        chk("areset_msb_valid", m_valid, 0);
        for (int t = 0; t < KS; t++) begin
            mx[t] = '0;
            mk[t] = '0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < KS; t += 2) begin
            load(0, t, 8'(3 * t + 7), 1);
            load(1, t, 8'(t * 11), 1);
        end
        run_window(0, 0, 0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
